// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory request controller.
package mem_req_pkg;

  localparam int WORD_W = 16;

  // addr[0] value that selects the high byte [15:8] (big-endian lanes)
  localparam logic LANE_HI_SEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake plus single-port memory bus for mem_req_ctrl.
interface mem_req_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  import mem_req_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic                  req_byte;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_W-1:0]     req_wdata;

  logic                  resp_valid;
  logic [WORD_W-1:0]     resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [WORD_W-1:0]     mem_wdata;
  logic [WORD_W-1:0]     mem_rdata;

  // Controller side
  modport slave (
    input  req_valid, req_wr, req_byte, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_enable, mem_wr, mem_wdata
  );

  // Requester plus memory side
  modport master (
    output req_valid, req_wr, req_byte, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_enable, mem_wr, mem_wdata
  );

endinterface

// File: rtl/mem_req_ctrl_byte_lane.sv
// Byte-lane extract (zero-extended) and merge for big-endian 16-bit words.
module byte_lane
  import mem_req_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [7:0]        byte_in,
  input  logic              sel,
  output logic [WORD_W-1:0] lane,
  output logic [WORD_W-1:0] merged
);

  // Select the addressed lane and build the word with that lane replaced
  always_comb begin
    if (sel == LANE_HI_SEL) begin
      lane   = {8'h00, word[15:8]};
      merged = {byte_in, word[7:0]};
    end else begin
      lane   = {8'h00, word[7:0]};
      merged = {word[15:8], byte_in};
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Requester-side controller: word/byte loads and stores onto a single-port
// 16-bit memory, byte stores done as read-modify-write.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  mem_req_ctrl_if.slave bus
);

  state_t                state;
  logic                  wr_q;
  logic                  byte_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [WORD_W-1:0]     data_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [WORD_W-1:0]     lane_word;
  logic [WORD_W-1:0]     lane_val;
  logic [WORD_W-1:0]     merged_val;

  assign word_addr = {addr_q[ADDR_WIDTH-1:1], 1'b0};

  // One lane unit serves both the load extract and the RMW merge: the word
  // comes from the memory in RD and from the captured copy in RMW_WR.
  assign lane_word = (state == RMW_WR) ? data_q : bus.mem_rdata;

  byte_lane u_lane (
    .word    (lane_word),
    .byte_in (wdata_q[7:0]),
    .sel     (addr_q[0]),
    .lane    (lane_val),
    .merged  (merged_val)
  );

  // State sequencing, request latch and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_wr;
            byte_q  <= bus.req_byte;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= ~bus.req_byte & bus.req_addr[0];
            data_q  <= '0;
            if (!bus.req_wr)       state <= RD;
            else if (bus.req_byte) state <= RMW_RD;
            else                   state <= WR;
          end
        end
        RD: begin
          data_q <= byte_q ? lane_val : bus.mem_rdata;
          state  <= RESP;
        end
        WR:      state <= RESP;
        RMW_RD: begin
          data_q <= bus.mem_rdata;
          state  <= RMW_WR;
        end
        RMW_WR:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      RD, RMW_RD: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = word_addr;
      end
      WR: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = word_addr;
        bus.mem_wdata  = wdata_q;
      end
      RMW_WR: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = word_addr;
        bus.mem_wdata  = merged_val;
      end
      RESP: begin
        bus.resp_rdata = wr_q ? '0 : data_q;
        bus.resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with a small memory model.
module tb_mem_req_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [15:0] mem_model [0:255];

  mem_req_ctrl_if #(.ADDR_WIDTH(16)) bus ();

  mem_req_ctrl #(.ADDR_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write on the rising edge
  assign bus.mem_rdata = mem_model[bus.mem_addr[8:1]];
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr) mem_model[bus.mem_addr[8:1]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, watch six cycles after acceptance, compare to expectations
  task automatic run_req(input logic wr, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata,
                         input logic exp_err, input int exp_lat,
                         input logic [15:0] exp_wdata);
    int nresp, lat, nwr, nrd, bad;
    logic [15:0] got_rd, waddr, wdat, raddr;
    logic got_err;
    logic [15:0] exp_waddr;
    nresp = 0; lat = 0; nwr = 0; nrd = 0; bad = 0;
    got_rd = '0; got_err = 1'b0; waddr = '0; wdat = '0; raddr = '0;
    exp_waddr = addr & 16'hFFFE;
    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_byte  = byt;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        nresp++;
        lat = cyc;
        got_rd = bus.resp_rdata;
        got_err = bus.resp_err;
      end else if (bus.resp_rdata != 16'h0 || bus.resp_err) bad++;
      if (bus.mem_enable && bus.mem_wr) begin
        nwr++; waddr = bus.mem_addr; wdat = bus.mem_wdata;
      end
      if (bus.mem_enable && !bus.mem_wr) begin
        nrd++; raddr = bus.mem_addr;
      end
      if (!bus.mem_enable && (bus.mem_addr != 16'h0 || bus.mem_wdata != 16'h0 || bus.mem_wr)) bad++;
      if (bus.mem_enable && bus.resp_valid) bad++;
    end
    check("idle_outputs_zero", bad, 0);
    check("resp_count", nresp, 1);
    check("resp_latency", lat, exp_lat);
    check("resp_rdata", {16'd0, got_rd}, {16'd0, exp_rdata});
    check("resp_err", {31'd0, got_err}, {31'd0, exp_err});
    check("read_count", nrd, (!wr || byt) ? 1 : 0);
    check("write_count", nwr, wr ? 1 : 0);
    if (!wr || byt) check("read_addr", {16'd0, raddr}, {16'd0, exp_waddr});
    if (wr) begin
      check("write_addr", {16'd0, waddr}, {16'd0, exp_waddr});
      check("write_data", {16'd0, wdat}, {16'd0, exp_wdata});
    end
  endtask

  initial begin
    int nresp;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0;

    #2;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_mem_enable", {31'd0, bus.mem_enable}, 32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Word store then load
    run_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2, 16'hBEEF);
    run_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2, 16'h0000);

    // Byte loads, big-endian lanes
    run_req(1'b1, 1'b0, 16'h0020, 16'h12AB, 16'h0000, 1'b0, 2, 16'h12AB);
    run_req(1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0012, 1'b0, 2, 16'h0000);
    run_req(1'b0, 1'b1, 16'h0021, 16'h0000, 16'h00AB, 1'b0, 2, 16'h0000);

    // Byte store RMW on low lane, then high lane with junk in wdata[15:8]
    run_req(1'b1, 1'b0, 16'h0030, 16'h1234, 16'h0000, 1'b0, 2, 16'h1234);
    run_req(1'b1, 1'b1, 16'h0031, 16'h00CD, 16'h0000, 1'b0, 3, 16'h12CD);
    run_req(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h12CD, 1'b0, 2, 16'h0000);
    run_req(1'b1, 1'b0, 16'h0032, 16'hAAAA, 16'h0000, 1'b0, 2, 16'hAAAA);
    run_req(1'b1, 1'b1, 16'h0032, 16'hFF55, 16'h0000, 1'b0, 3, 16'h55AA);
    run_req(1'b0, 1'b0, 16'h0032, 16'h0000, 16'h55AA, 1'b0, 2, 16'h0000);

    // Misaligned word accesses: flagged, performed on the aligned word
    run_req(1'b1, 1'b0, 16'h0040, 16'h5555, 16'h0000, 1'b0, 2, 16'h5555);
    run_req(1'b0, 1'b0, 16'h0041, 16'h0000, 16'h5555, 1'b1, 2, 16'h0000);
    run_req(1'b1, 1'b0, 16'h0043, 16'h9999, 16'h0000, 1'b1, 2, 16'h9999);
    run_req(1'b0, 1'b0, 16'h0042, 16'h0000, 16'h9999, 1'b0, 2, 16'h0000);

    // req_valid held high: ready low for two cycles, one response per accept
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 16'h0010;
    nresp = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        nresp++;
        check("held_rdata", {16'd0, bus.resp_rdata}, 32'h0000BEEF);
      end
      check("held_ready", {31'd0, bus.req_ready}, (cyc % 3 == 0) ? 32'd1 : 32'd0);
      if (cyc == 5) bus.req_valid = 1'b0;
    end
    check("held_resp_count", nresp, 2);

    // Reset during RMW_WR: write suppressed, no response
    run_req(1'b1, 1'b0, 16'h0050, 16'h7777, 16'h0000, 1'b0, 2, 16'h7777);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_byte  = 1'b1;
    bus.req_addr  = 16'h0050;
    bus.req_wdata = 16'h0011;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_drive", {30'd0, bus.mem_enable, bus.mem_wr}, 32'd2);
    @(negedge clk);
    check("rmw_wr_drive", {30'd0, bus.mem_enable, bus.mem_wr}, 32'd3);
    check("rmw_wr_data", {16'd0, bus.mem_wdata}, 32'h00001177);
    #1 rst = 1'b1;
    #1;
    check("rst_async_enable", {31'd0, bus.mem_enable}, 32'd0);
    check("rst_async_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("rst_word_kept", {16'd0, mem_model[8'h28]}, 32'h00007777);
    nresp = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    check("rst_no_resp", nresp, 0);
    run_req(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h7777, 1'b0, 2, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Requester-side controller for the 16-bit, word-organised, byte-addressed single-port memory used for instruction and data storage. It accepts word and byte load/store requests from the pipeline MEM stage over a valid/ready handshake. It drives the memory port (enable, wr, addr, data) one access per cycle, honouring the rule of no concurrent read and write. Byte stores are turned into a read-modify-write sequence.

## Interface
- ADDR_WIDTH, 16, byte-address width; memory word index is addr[ADDR_WIDTH-1:1]
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_wr  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  16  store data; byte store uses [7:0]
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  16  load data, zero-extended for byte loads; 0 for stores
- resp_err  out  1  with resp_valid: word access with req_addr[0]=1
- mem_addr  out  ADDR_WIDTH  to memory addr; bit 0 always 0
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_wdata  out  16  to memory data_in
- mem_rdata  in  16  from memory data_out; combinational, valid in the same cycle as enable & ~wr

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. Outputs mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - On req_valid, latch wr, byte, addr and wdata.
  - Next state: word load or byte load goes to RD; word store goes to WR; byte store goes to RMW_RD.
- RD: mem_enable=1, mem_wr=0, mem_addr={addr[ADDR_WIDTH-1:1],0}.
  - Capture mem_rdata at the edge.
  - Byte load selects a lane and zero-extends it. Lanes are big-endian: addr[0]=0 selects [15:8]; addr[0]=1 selects [7:0].
  - Next state: RESP.
- WR: mem_enable=1, mem_wr=1, mem_wdata=latched wdata. Next state: RESP.
- RMW_RD: same port drive as RD. Capture the full word. Next state: RMW_WR.
- RMW_WR: mem_enable=1, mem_wr=1. mem_wdata is the captured word with the selected lane replaced by wdata[7:0]; the other lane is unchanged. Next state: RESP.
- RESP: resp_valid=1, resp_rdata=result (0 for stores), resp_err as latched. mem_enable=0. Next state: IDLE.
- Misaligned word access: resp_err=1. The access is still performed on the aligned word.
- Byte accesses are never errors.
- While resp_valid=0, resp_rdata and resp_err hold 0.
- All outputs are decoded from registered state. There is no combinational path from req_* to mem_*.

## Timing
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_enable=0; mem_wr=0; mem_addr=0; mem_wdata=0; all latches 0.
- Request accepted at edge N (req_valid & req_ready).
  - Word load/store: access in cycle N+1, resp_valid in cycle N+2, req_ready back in N+3.
  - Byte load: identical to word load.
  - Byte store: read in N+1, write in N+2, resp_valid in N+3.
- Throughput: one word request per 3 cycles; one byte store per 4 cycles.
- req_valid outside IDLE is ignored. The requester holds the request until req_ready.
- mem_enable & mem_wr and mem_enable & ~mem_wr are never high together with differing addresses within one cycle. Read and write never share a cycle.
- Reset asserted mid-operation forces all outputs to reset values immediately (asynchronous).
  - A write whose WR/RMW_WR cycle is cut by reset before the edge does not occur.
  - No resp_valid is issued for the aborted request.
  - After reset deasserts, the first edge still finds IDLE.

## Structure
- Package mem_req_pkg holds:
  - state enum (IDLE, RD, WR, RMW_RD, RMW_WR, RESP)
  - constant LANE_HI_SEL=1'b0 (addr[0] value selecting [15:8])
  - WORD_W=16
- One sub-module, byte_lane: combinational extract (lane to zero-extended 16-bit) and merge (word, byte, addr[0] to word). It is shared by the RD and RMW_WR paths.

## Test plan
- Word store then load:
  - store addr 0x0010, data 0xBEEF; WR cycle shows mem_enable=1, mem_wr=1, mem_addr=0x0010.
  - load 0x0010 -> resp_rdata=0xBEEF, resp_err=0, resp_valid exactly 2 cycles after acceptance.
- Byte loads:
  - preload 0x0020=0x12AB.
  - byte load 0x0020 -> 0x0012.
  - byte load 0x0021 -> 0x00AB.
- Byte store RMW:
  - 0x0030=0x1234; byte store 0x0031 data 0x00CD.
  - Sequence: RMW_RD then RMW_WR with mem_wdata=0x12CD; resp_valid 3 cycles after acceptance.
  - Word load -> 0x12CD.
- Misaligned word:
  - load 0x0041 with mem word 0x0040=0x5555 -> mem_addr=0x0040, resp_rdata=0x5555, resp_err=1.
- Handshake:
  - req_valid held high continuously -> req_ready low from N+1 to N+2.
  - Exactly one response per accepted request.
  - mem_enable & mem_wr never asserted in the same cycle as a read.
- Reset mid-RMW:
  - assert rst during RMW_WR before the edge -> mem_enable drops immediately; target word is unchanged on reload; no resp_valid.
  - req_ready=1 after reset release.
